cordic_issue: RTL and testbench

//  Initiator that drives the iterative CORDIC core (Xo/Yo/Zo in, mode m, Xout/Yout/Zout out).

---
 rtl/cordic_issue_if.sv | 54 +++++
 rtl/cordic_issue.sv | 186 ++++++++++++++++++
 tb/tb_cordic_issue.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_issue_if.sv
// ---------------------------------------------------------------------------
// cordic_issue_if
//   Request/result bundle between the neuron/activation sequencer and the
//   CORDIC issue block.
//
//   Request channel (sequencer -> block):
//     in_valid, in_m, in_x, in_y, in_z, in_tag   driven by the sequencer
//     in_ready                                   driven by the block
//   Result channel (block -> sequencer):
//     out_valid, out_x, out_y, out_z, out_tag    driven by the block
//     out_ready                                  driven by the sequencer
//
//   Handshake rule, both channels: a transfer happens on a rising clock edge
//   where valid and ready are both high. A producer holding valid keeps its
//   payload stable until that transfer. A consumer may raise or drop ready
//   at any time. Ready may depend combinationally on the other channel
//   (in_ready follows out_ready while a result is held) but never on the
//   valid of its own channel.
//
//   Modports:
//     master  sequencer view (issues requests, consumes results)
//     slave   issue-block view (accepts requests, produces results)
// ---------------------------------------------------------------------------
interface cordic_issue_if #(
  parameter int WIDTH = 15,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic             in_m;
  logic [WIDTH:0]   in_x;
  logic [WIDTH:0]   in_y;
  logic [WIDTH:0]   in_z;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_x;
  logic [WIDTH:0]   out_y;
  logic [WIDTH:0]   out_z;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_m, in_x, in_y, in_z, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_tag
  );

  modport slave (
    input  in_valid, in_m, in_x, in_y, in_z, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_tag
  );

endinterface

// File: rtl/cordic_issue.sv
// ---------------------------------------------------------------------------
// cordic_issue
//   Issue/capture wrapper around the iterative CORDIC core. Accepts one
//   operand set per request, restarts the core for one cycle, keeps the
//   operands and mode stable for the whole iteration window, then captures
//   the core outputs together with the request tag and presents them until
//   the consumer takes them. Exactly one operation is in flight.
//
// Parameters
//   WIDTH    MSB index of data buses (buses are [WIDTH:0])
//   LATENCY  core cycles from restart release to valid core outputs (>= 1)
//   TAG_W    width of the opaque request tag
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   bus        cordic_issue_if.slave: request channel (in_*) and result
//              channel (out_*)
//   core_rst   restart to the core, active-high; held high while in reset
//   core_m     mode bit to the core
//   core_xo/core_yo/core_zo        operands to the core
//   core_xout/core_yout/core_zout  results from the core
//   busy       high whenever the block is not idle
//   dbg_state  current FSM state (0 IDLE, 1 START, 2 RUN, 3 HOLD)
//
// Timing (E0 = edge that accepts a request)
//   core_rst is high for the single cycle after E0, the counter then runs
//   0..LATENCY-1 in RUN, and the capture edge is E0+LATENCY+1, so out_valid
//   is first high in cycle E0+LATENCY+2. A result handshake that coincides
//   with a new request re-enters START directly, giving one op every
//   LATENCY+2 cycles.
// ---------------------------------------------------------------------------
module cordic_issue #(
  parameter int WIDTH   = 15,
  parameter int LATENCY = 17,
  parameter int TAG_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  cordic_issue_if.slave  bus,
  output logic           core_rst,
  output logic           core_m,
  output logic [WIDTH:0] core_xo,
  output logic [WIDTH:0] core_yo,
  output logic [WIDTH:0] core_zo,
  input  logic [WIDTH:0] core_xout,
  input  logic [WIDTH:0] core_yout,
  input  logic [WIDTH:0] core_zout,
  output logic           busy,
  output logic [1:0]     dbg_state
);

  // Elaboration-time guard: a zero-latency core cannot be sequenced here.
  if (LATENCY < 1) begin : g_bad_latency
    $error("cordic_issue: LATENCY must be >= 1");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int             CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;

  logic             in_ready_w;
  logic             accept;
  logic             capture;

  logic [TAG_W-1:0] tag_q;
  logic [WIDTH:0]   out_x_q;
  logic [WIDTH:0]   out_y_q;
  logic [WIDTH:0]   out_z_q;
  logic [TAG_W-1:0] out_tag_q;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // While a result is held, a new request may only enter on the same edge the
  // result leaves, so in_ready mirrors out_ready there.
  always_comb begin
    in_ready_w = 1'b0;
    case (state)
      ST_IDLE: in_ready_w = 1'b1;
      ST_HOLD: in_ready_w = bus.out_ready;
      default: in_ready_w = 1'b0;
    endcase
  end

  assign accept  = bus.in_valid && in_ready_w;
  assign capture = (state == ST_RUN) && (cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_START;
      end
      ST_START: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (capture) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // accept here already implies out_ready (in_ready == out_ready).
        if (bus.out_ready) state_nxt = accept ? ST_START : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counter, operand and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      core_rst  <= 1'b1;
      core_m    <= 1'b0;
      core_xo   <= '0;
      core_yo   <= '0;
      core_zo   <= '0;
      tag_q     <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      out_z_q   <= '0;
      out_tag_q <= '0;
    end else begin
      state <= state_nxt;

      // Registered restart: high exactly during the START cycle, so the core
      // never sees a combinational glitch on its restart input.
      core_rst <= (state_nxt == ST_START);

      // Operands change only on an accepted request and are otherwise held
      // for the whole iteration window.
      if (accept) begin
        core_m  <= bus.in_m;
        core_xo <= bus.in_x;
        core_yo <= bus.in_y;
        core_zo <= bus.in_z;
        tag_q   <= bus.in_tag;
      end

      // Counter is cleared in START and stops at LATENCY-1; it never wraps.
      if (state == ST_START) begin
        cnt <= '0;
      end else if ((state == ST_RUN) && (cnt != CNT_LAST)) begin
        cnt <= cnt + CNT_ONE;
      end

      if (capture) begin
        out_x_q   <= core_xout;
        out_y_q   <= core_yout;
        out_z_q   <= core_zout;
        out_tag_q <= tag_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_z     = out_z_q;
  assign bus.out_tag   = out_tag_q;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_cordic_issue.sv
// ---------------------------------------------------------------------------
// tb_cordic_issue
//   Directed bench for cordic_issue. Contains a simple CORDIC core stand-in
//   (outputs garbage until LATENCY-1 cycles after restart release, then a
//   fixed function of its operands), a transaction-level model of the issue
//   block checked on every falling edge, and directed scenarios with literal
//   expectations.
// ---------------------------------------------------------------------------
module tb_cordic_issue;

  localparam int WIDTH   = 15;
  localparam int LATENCY = 17;
  localparam int TAG_W   = 4;
  localparam int W       = 3 * (WIDTH + 1) + TAG_W;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b0;

  initial forever #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // DUT and core stand-in
  // -------------------------------------------------------------------------
  cordic_issue_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  logic           core_rst;
  logic           core_m;
  logic [WIDTH:0] core_xo, core_yo, core_zo;
  logic [WIDTH:0] core_xout, core_yout, core_zout;
  logic           busy;
  logic [1:0]     dbg_state;

  cordic_issue #(.WIDTH(WIDTH), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .core_rst  (core_rst),
    .core_m    (core_m),
    .core_xo   (core_xo),
    .core_yo   (core_yo),
    .core_zo   (core_zo),
    .core_xout (core_xout),
    .core_yout (core_yout),
    .core_zout (core_zout),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Core stand-in: iteration count since restart; outputs are only
  // meaningful once LATENCY-1 cycles have elapsed after restart release.
  int core_cnt = 255;
  always @(posedge clk) begin
    if (core_rst) core_cnt <= 0;
    else if (core_cnt < 255) core_cnt <= core_cnt + 1;
  end

  assign core_xout = (core_cnt >= LATENCY - 1) ? core_xo + 16'h0001 : 16'hdead;
  assign core_yout = (core_cnt >= LATENCY - 1) ? core_yo + 16'h0100 : 16'hbeef;
  assign core_zout = (core_cnt >= LATENCY - 1) ?
                     (core_m ? ~core_zo : core_zo ^ 16'h00ff) : 16'hcafe;

  // -------------------------------------------------------------------------
  // Check bookkeeping
  // -------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Transaction-level model / scoreboard
  // -------------------------------------------------------------------------
  function automatic logic [W-1:0] expect_result(input logic m, input logic [15:0] x,
                                                 input logic [15:0] y, input logic [15:0] z,
                                                 input logic [3:0] tag);
    logic [15:0] rx, ry, rz;
    rx = x + 16'h0001;
    ry = y + 16'h0100;
    rz = m ? ~z : (z ^ 16'h00ff);
    return {rx, ry, rz, tag};
  endfunction

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_out      = '0;
  bit           m_valid    = 1'b0;
  int           m_wait     = 0;     // edges left until the result shows; 0 = none pending
  bit           m_core_rst = 1'b1;
  logic [48:0]  m_ops      = '0;    // {m, x, y, z} last accepted

  // Result handshake log (actual observations) used by directed checks.
  logic [3:0] hs_tag_q[$];
  int         hs_cyc_q[$];
  int         ncyc = 0;

  always @(negedge clk) begin
    bit exp_in_ready;
    bit hs;
    bit acc;
    exp_in_ready = (m_wait == 0) && (!m_valid || bus.out_ready);

    check("in_ready",  bus.in_ready, exp_in_ready);
    check("out_valid", bus.out_valid, m_valid);
    check("busy",      busy, (m_wait > 0) || m_valid);
    check("core_rst",  core_rst, m_core_rst);
    check("core_ops",  {core_m, core_xo, core_yo, core_zo}, m_ops);
    check("out_data",  {bus.out_x, bus.out_y, bus.out_z, bus.out_tag}, m_out);

    if (bus.out_valid && bus.out_ready) begin
      hs_tag_q.push_back(bus.out_tag);
      hs_cyc_q.push_back(ncyc);
    end

    // Advance the model across the coming rising edge.
    if (!reset) begin
      exp_q.delete();
      m_out      = '0;
      m_valid    = 1'b0;
      m_wait     = 0;
      m_core_rst = 1'b1;
      m_ops      = '0;
    end else begin
      hs  = m_valid && bus.out_ready;
      acc = bus.in_valid && exp_in_ready;
      if (hs) m_valid = 1'b0;
      if (acc) begin
        exp_q.push_back(expect_result(bus.in_m, bus.in_x, bus.in_y, bus.in_z, bus.in_tag));
        m_ops  = {bus.in_m, bus.in_x, bus.in_y, bus.in_z};
        m_wait = LATENCY + 2;
      end
      m_core_rst = acc;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_out   = exp_q.pop_front();
        end
      end
    end
    ncyc++;
  end

  // -------------------------------------------------------------------------
  // Driver tasks (called at posedge+2)
  // -------------------------------------------------------------------------
  task automatic send_req(input logic m, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z, input logic [3:0] tag, input bit drop);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_m     = m;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_z     = z;
    bus.in_tag   = tag;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    check("req_accept", acc, 1'b1);
    if (drop) bus.in_valid = 1'b0;
  endtask

  // Counts falling edges after the accept edge until out_valid; 61 = timeout.
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n <= 60);
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  initial begin
    int n;

    // Reset held with a request pending.
    bus.in_valid  = 1'b1;
    bus.in_m      = 1'b0;
    bus.in_x      = 16'h5555;
    bus.in_y      = 16'h0000;
    bus.in_z      = 16'h0000;
    bus.in_tag    = 4'h0;
    bus.out_ready = 1'b0;
    reset         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_core_rst", core_rst, 1'b1);
    check("t1_out_valid", bus.out_valid, 1'b0);
    check("t1_out_zero", {bus.out_x, bus.out_y, bus.out_z, bus.out_tag}, 52'h0);
    check("t1_core_xo", core_xo, 16'h0000);
    check("t1_dbg_state", dbg_state, 2'd0);
    @(posedge clk);
    #2;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_in_ready", bus.in_ready, 1'b1);
    check("t1_out_valid_rel", bus.out_valid, 1'b0);

    // Single op with latency and restart-pulse timing.
    @(posedge clk);
    #2;
    send_req(1'b0, 16'h1000, 16'h0020, 16'h0300, 4'd3, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("t2_core_rst_hi", core_rst, 1'b1);
      if (n == 2) check("t2_core_rst_lo", core_rst, 1'b0);
    end while (!bus.out_valid && n <= 60);
    check("t2_latency", n, 19);
    check("t2_out_x", bus.out_x, 16'h1001);
    check("t2_out_y", bus.out_y, 16'h0120);
    check("t2_out_z", bus.out_z, 16'h03ff);
    check("t2_out_tag", bus.out_tag, 4'd3);

    // Backpressure: result held, new request ignored.
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.in_x     = 16'h7777;
    bus.in_tag   = 4'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_in_ready", bus.in_ready, 1'b0);
      check("t3_out_x", bus.out_x, 16'h1001);
      check("t3_out_tag", bus.out_tag, 4'd3);
    end
    @(posedge clk);
    #2;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("t3_out_valid_drop", bus.out_valid, 1'b0);
    check("t3_busy_drop", busy, 1'b0);

    // Back-to-back: in_valid held, out_ready high.
    @(posedge clk);
    #2;
    hs_tag_q.delete();
    hs_cyc_q.delete();
    for (int k = 0; k < 3; k++) begin
      send_req(k[0], 16'h2000 + 16'(k), 16'h0030 + 16'(k), 16'h0a00 + 16'(k), 4'(k), k == 2);
    end
    n = 0;
    while (hs_tag_q.size() < 3 && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t4_hs_count", hs_tag_q.size(), 3);
    if (hs_tag_q.size() == 3) begin
      check("t4_tag0", hs_tag_q[0], 4'd0);
      check("t4_tag1", hs_tag_q[1], 4'd1);
      check("t4_tag2", hs_tag_q[2], 4'd2);
      check("t4_spacing01", hs_cyc_q[1] - hs_cyc_q[0], 19);
      check("t4_spacing12", hs_cyc_q[2] - hs_cyc_q[1], 19);
    end

    // Operand stability while in_x wiggles during RUN.
    @(posedge clk);
    #2;
    send_req(1'b0, 16'h4242, 16'h0001, 16'h0002, 4'd5, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      bus.in_x = 16'h0101 * 16'(i);
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    check("t5_core_xo", core_xo, 16'h4242);
    wait_result(n);
    check("t5_done", bus.out_valid, 1'b1);
    check("t5_out_x", bus.out_x, 16'h4243);
    check("t5_out_tag", bus.out_tag, 4'd5);

    // Reset in the middle of RUN (counter at 8), then a fresh op.
    @(posedge clk);
    #2;
    send_req(1'b0, 16'h0abc, 16'h0000, 16'h0000, 4'd6, 1'b1);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("t6_no_valid", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #2;
    send_req(1'b1, 16'h1234, 16'h0001, 16'h0f0f, 4'd12, 1'b1);
    wait_result(n);
    check("t6_latency", n, 19);
    check("t6_out_x", bus.out_x, 16'h1235);
    check("t6_out_y", bus.out_y, 16'h0101);
    check("t6_out_z", bus.out_z, 16'hf0f0);
    check("t6_out_tag", bus.out_tag, 4'd12);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
